// File: rtl/opb_regbank_pkg.sv
// Shared types and helpers for the OPB register bank: bus FSM states,
// the OPB data width and the byte-lane (BE[0:3] -> bits 31:0) expansion.
package opb_regbank_pkg;

    localparam int OPB_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK     = 2'd1,
        ST_RECOVER = 2'd2
    } opb_state_e;

    // OPB numbers bytes big-endian: BE[0] covers DBus[0:7], i.e. bits 31:24.
    function automatic logic [OPB_DW-1:0] be_to_mask(input logic [0:3] be);
        logic [OPB_DW-1:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                mask[OPB_DW-1-8*b -: 8] = 8'hFF;
            end
        end
        return mask;
    endfunction

    function automatic logic [OPB_DW-1:0] be_merge(input logic [OPB_DW-1:0] old_val,
                                                   input logic [OPB_DW-1:0] new_val,
                                                   input logic [OPB_DW-1:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/opb_regbank_cell.sv
// One control register: byte-enable merge, optional self-clearing pulse mode
// and a one-cycle update strobe. OPB_REG_SHADOW_COMMIT_EN adds a shadow stage.
module opb_regbank_cell
    import opb_regbank_pkg::*;
#(
    parameter bit              PULSE     = 1'b0,
    parameter logic [OPB_DW-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [OPB_DW-1:0] be_mask,
    input  logic [OPB_DW-1:0] wr_data,
`ifdef OPB_REG_SHADOW_COMMIT_EN
    input  logic              commit,
`endif
    output logic [OPB_DW-1:0] data_out,
    output logic [OPB_DW-1:0] rd_value,
    output logic              update
);

    localparam logic [OPB_DW-1:0] INIT_VAL = PULSE ? '0 : RESET_VAL;

    logic              wr_any;
    logic [OPB_DW-1:0] value_p1;
    logic              upd_p1;

    assign wr_any = wr_en && (be_mask != '0);

`ifdef OPB_REG_SHADOW_COMMIT_EN
    logic [OPB_DW-1:0] shadow_p1;
    logic              dirty_p1;

    // Writes only touch the shadow; commit moves it to the output and
    // reports whether this register was written since the last commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_p1 <= INIT_VAL;
            value_p1  <= INIT_VAL;
            dirty_p1  <= 1'b0;
            upd_p1    <= 1'b0;
        end else begin
            upd_p1 <= commit && dirty_p1;
            if (wr_any) begin
                shadow_p1 <= be_merge(PULSE ? '0 : shadow_p1, wr_data, be_mask);
                dirty_p1  <= 1'b1;
            end
            if (commit) begin
                value_p1 <= shadow_p1;
                dirty_p1 <= 1'b0;
                if (PULSE) begin
                    shadow_p1 <= '0;
                end
            end else if (PULSE) begin
                value_p1 <= '0;
            end
        end
    end

    assign rd_value = PULSE ? '0 : shadow_p1;
`else
    // Pulse registers hold the written bytes for one cycle, unwritten bytes 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_p1 <= INIT_VAL;
            upd_p1   <= 1'b0;
        end else begin
            upd_p1 <= wr_any;
            if (wr_any) begin
                value_p1 <= be_merge(PULSE ? '0 : value_p1, wr_data, be_mask);
            end else if (PULSE) begin
                value_p1 <= '0;
            end
        end
    end

    assign rd_value = PULSE ? '0 : value_p1;
`endif

    assign data_out = value_p1;
    assign update   = upd_p1;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS PPC-writable control registers to user logic.
// Optional build macro: OPB_REG_SHADOW_COMMIT_EN (shadowed writes + commit word).
module opb_register_bank_ppc2simulink
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h010B2400,
    parameter logic [31:0] C_HIGHADDR   = 32'h010B24FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_REGS   = 4,
    parameter logic [15:0] C_PULSE_MASK = 16'h0,
    parameter logic [31:0] C_RESET_VAL  = 32'h0
) (
    input  logic                       OPB_Clk,
    input  logic                       OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]    OPB_ABus,
    input  logic [0:3]                 OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]    OPB_DBus,
    input  logic                       OPB_RNW,
    input  logic                       OPB_select,
    input  logic                       OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]    Sl_DBus,
    output logic                       Sl_xferAck,
    output logic                       Sl_errAck,
    output logic                       Sl_retry,
    output logic                       Sl_toutSup,
    output logic [C_NUM_REGS*32-1:0]   user_data_out,
    output logic [C_NUM_REGS-1:0]      user_update
);

    opb_state_e                state;
    logic                      hit;
    logic                      wr_fire;
    logic [C_OPB_AWIDTH-1:0]   offset;
    logic [C_OPB_AWIDTH-1:0]   word_idx;
    logic [OPB_DW-1:0]         lane_mask;
    logic [OPB_DW-1:0]         wr_data;
    logic [OPB_DW-1:0]         rd_data;
    logic [OPB_DW-1:0]         cell_out [C_NUM_REGS];
    logic [OPB_DW-1:0]         cell_rd  [C_NUM_REGS];
    logic                      unused_seq;

    assign unused_seq = OPB_seqAddr;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    // Address decode; the two byte-offset bits drop out of the word index.
    assign hit       = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    assign offset    = OPB_ABus - C_BASEADDR;
    assign word_idx  = offset >> 2;
    assign wr_fire   = (state == ST_IDLE) && hit && !OPB_RNW;
    assign lane_mask = be_to_mask(OPB_BE);
    assign wr_data   = OPB_DBus;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (word_idx == C_OPB_AWIDTH'(i)) begin
                rd_data = cell_rd[i];
            end
        end
    end

`ifdef OPB_REG_SHADOW_COMMIT_EN
    logic commit_fire;
    assign commit_fire = wr_fire && (word_idx == C_OPB_AWIDTH'(C_NUM_REGS));
`endif

    for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_reg
        logic wr_sel;
        assign wr_sel = wr_fire && (word_idx == C_OPB_AWIDTH'(i));

        opb_regbank_cell #(
            .PULSE     (C_PULSE_MASK[i]),
            .RESET_VAL (C_RESET_VAL)
        ) u_cell (
            .clk      (OPB_Clk),
            .rst      (OPB_Rst),
            .wr_en    (wr_sel),
            .be_mask  (lane_mask),
            .wr_data  (wr_data),
`ifdef OPB_REG_SHADOW_COMMIT_EN
            .commit   (commit_fire),
`endif
            .data_out (cell_out[i]),
            .rd_value (cell_rd[i]),
            .update   (user_update[i])
        );

        assign user_data_out[32*i +: 32] = cell_out[i];
    end

    // Ack and read data are registered on the IDLE->ACK edge, the same edge
    // that commits a write; RECOVER blocks a second ack while select is held.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state      <= ST_IDLE;
            Sl_xferAck <= 1'b0;
            Sl_DBus    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        state      <= ST_ACK;
                        Sl_xferAck <= 1'b1;
                        Sl_DBus    <= OPB_RNW ? rd_data : '0;
                    end else begin
                        Sl_xferAck <= 1'b0;
                        Sl_DBus    <= '0;
                    end
                end
                ST_ACK: begin
                    state      <= ST_RECOVER;
                    Sl_xferAck <= 1'b0;
                    Sl_DBus    <= '0;
                end
                ST_RECOVER: begin
                    state      <= ST_IDLE;
                    Sl_xferAck <= 1'b0;
                    Sl_DBus    <= '0;
                end
                default: begin
                    state      <= ST_IDLE;
                    Sl_xferAck <= 1'b0;
                    Sl_DBus    <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
Name: opb_register_bank_ppc2simulink

Overview:
- Parametrised successor to the single OPB software register: a bank of C_NUM_REGS 32-bit PPC-writable, readable control registers behind one OPB slave decode.
- Adds a per-register pulse (self-clearing) mode, per-register update strobes, byte-enable writes and readback.
- Sits on the ROACH OPB bus; feeds Simulink user logic (DAC start, arm and trigger controls) in the OPB_Clk domain.

Parameters:
C_BASEADDR, 32'h010B2400, first byte address of the bank
C_HIGHADDR, 32'h010B24FF, last byte address; span must be >= 4*(C_NUM_REGS+1) bytes
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width; only 32 is supported
C_NUM_REGS, 4, number of registers, 1..16
C_PULSE_MASK, 0, bit i set = register i is self-clearing (pulse mode)
C_RESET_VAL, 32'h0, reset value of every level-mode register

Ports:
OPB_Clk  in  1  sole clock; the user side is also in this domain
OPB_Rst  in  1  synchronous, active-high reset
OPB_ABus  in  [0:31]  address
OPB_BE  in  [0:3]  byte enables; BE[0] selects DBus[0:7], which is user bits 31:24
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1 = read, 0 = write
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  sequential hint; ignored
Sl_DBus  out  [0:31]  read data; zero except during the ack cycle
Sl_xferAck  out  1  transfer acknowledge
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
user_data_out  out  [C_NUM_REGS*32-1:0]  register i occupies bits 32i+31:32i
user_update  out  [C_NUM_REGS-1:0]  one-cycle strobe when register i takes a new value

Behaviour:
- Single clock, OPB_Clk. Reset is synchronous and active-high on OPB_Rst.
- Reset values: level registers = C_RESET_VAL; pulse registers = 0; Sl_DBus = 0; Sl_xferAck = 0; user_update = 0; FSM = IDLE.
- Hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Word index = (OPB_ABus - C_BASEADDR) >> 2; OPB_ABus[30:31] is ignored.
- FSM IDLE -> ACK:
  - IDLE: a hit moves the FSM to ACK on the next edge.
  - ACK (exactly 1 cycle): Sl_xferAck=1. A write commits at this edge. For a read, Sl_DBus carries the data.
  - ACK -> RECOVER (1 cycle, xferAck=0) -> IDLE. This prevents a double ack while the master still holds select.
- Latency: Sl_xferAck rises in the cycle after select is first sampled, i.e. 2 cycles from select to ack.
- Write, index < C_NUM_REGS:
  - Each byte with BE=1 is replaced; bytes with BE=0 are kept.
  - user_update[i] pulses in the cycle after commit if any BE bit is 1.
  - BE=0000: acked, no change, no strobe.
- Pulse-mode register:
  - Written value drives user_data_out for exactly one cycle, the cycle after commit, then returns to 0.
  - Unwritten bytes are 0 during that pulse.
  - Readback returns 0.
- Read: returns the level register value. Index >= C_NUM_REGS reads 0 and is still acked.
- Write to index >= C_NUM_REGS: acked and discarded, except the commit address below.
- OPB_select dropping in ACK (master abort): ack is still issued once; the FSM returns to IDLE via RECOVER.
- Back-to-back transfers: at most one ack per 3 cycles.
- Reset asserted mid-transfer: takes effect at that edge. No ack follows. A pending write is dropped.

Optional Feature:
OPB_REG_SHADOW_COMMIT_EN
- Defined:
  - Writes land in shadow registers and are not visible on user_data_out.
  - A write to word index C_NUM_REGS (the commit register; data ignored) copies all shadows to outputs in the same cycle.
  - It pulses user_update for every register written since the previous commit; pulse registers fire together.
  - Reads return the shadow values.
- Undefined: direct update as above. Index C_NUM_REGS behaves as an ordinary out-of-range address.

Decomposition:
- Package opb_regbank_pkg:
  - FSM state enum (IDLE/ACK/RECOVER)
  - OPB data width constant of 32
  - Byte-lane helper function that maps BE[0:3] onto bits 31:0
- Sub-module opb_regbank_cell: one register with byte-enable merge, pulse-mode clear and update strobe. It is instantiated C_NUM_REGS times via generate.

Test Plan:
- Reset, then read idx0..3 -> each returns 0x00000000; xferAck exactly 1 cycle, 2 cycles after select.
- Write idx1 = 0xDEADBEEF with BE=1111, then read idx1 -> 0xDEADBEEF; user_update = 0010 for one cycle.
- Write idx1 = 0x11223344 with BE=0101 -> reads 0xDE22BE44; BE=0000 write -> no change, no strobe.
- C_PULSE_MASK=4'b0001; write idx0 = 0x1 -> user_data_out[31:0] = 1 for exactly one cycle, then 0; readback 0.
- Write to 0x010B2430 (index 12, out of range) -> acked, no register or strobe changes; read returns 0.
- Assert OPB_Rst in the ACK-pending cycle of a write of 0xA5A5A5A5 to idx2 -> no ack, idx2 reads C_RESET_VAL.
- With OPB_REG_SHADOW_COMMIT_EN: write idx0 and idx3, outputs unchanged; write the commit address -> both outputs update in the same cycle; user_update = 1001.
